// File: rtl/servile_mem_arbiter_pkg.sv
// Shared definitions for the servile memory arbiter: master indices,
// FSM state encoding and small address/ordering helpers.
package servile_arb_pkg;

  localparam logic [1:0] M_IBUS = 2'd0;
  localparam logic [1:0] M_DBUS = 2'd1;
  localparam logic [1:0] M_EXT  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_GUARD   = 2'd2,
    ST_RECOVER = 2'd3
  } arb_state_t;

  function automatic logic in_rf_region(input logic [31:0] adr, input logic [31:0] rf_base);
    return adr >= rf_base;
  endfunction

  // Circular successor ibus -> dbus -> ext -> ibus.
  function automatic logic [1:0] next_master(input logic [1:0] m);
    return (m == M_EXT) ? M_IBUS : m + 2'd1;
  endfunction

endpackage

// File: rtl/servile_mem_arbiter_if.sv
// Bundle of the three master ports and the shared SRAM Wishbone port.
// The arbiter uses the slave view; the surrounding system uses the master view.
interface servile_mem_arbiter_if #(parameter int aw = 8);

  logic [aw-3:0] i_ibus_adr;
  logic          i_ibus_stb;
  logic [31:0]   o_ibus_rdt;
  logic          o_ibus_ack;

  logic [aw-3:0] i_dbus_adr;
  logic [31:0]   i_dbus_dat;
  logic [3:0]    i_dbus_sel;
  logic          i_dbus_we;
  logic          i_dbus_stb;
  logic [31:0]   o_dbus_rdt;
  logic          o_dbus_ack;

  logic [aw-3:0] i_ext_adr;
  logic [31:0]   i_ext_dat;
  logic [3:0]    i_ext_sel;
  logic          i_ext_we;
  logic          i_ext_stb;
  logic [31:0]   o_ext_rdt;
  logic          o_ext_ack;

  logic [aw-3:0] o_wb_adr;
  logic [31:0]   o_wb_dat;
  logic [3:0]    o_wb_sel;
  logic          o_wb_we;
  logic          o_wb_stb;
  logic [31:0]   i_wb_rdt;
  logic          i_wb_ack;

  logic          o_guard_err;

  modport slave (
    input  i_ibus_adr, i_ibus_stb,
    output o_ibus_rdt, o_ibus_ack,
    input  i_dbus_adr, i_dbus_dat, i_dbus_sel, i_dbus_we, i_dbus_stb,
    output o_dbus_rdt, o_dbus_ack,
    input  i_ext_adr, i_ext_dat, i_ext_sel, i_ext_we, i_ext_stb,
    output o_ext_rdt, o_ext_ack,
    output o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_stb,
    input  i_wb_rdt, i_wb_ack,
    output o_guard_err
  );

  modport master (
    output i_ibus_adr, i_ibus_stb,
    input  o_ibus_rdt, o_ibus_ack,
    output i_dbus_adr, i_dbus_dat, i_dbus_sel, i_dbus_we, i_dbus_stb,
    input  o_dbus_rdt, o_dbus_ack,
    output i_ext_adr, i_ext_dat, i_ext_sel, i_ext_we, i_ext_stb,
    input  o_ext_rdt, o_ext_ack,
    input  o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_stb,
    output i_wb_rdt, i_wb_ack,
    input  o_guard_err
  );

endinterface

// File: rtl/servile_mem_arbiter_rr_pick.sv
// Combinational 3-way round-robin picker: first active request found
// scanning circularly from ptr wins.
module servile_rr_pick
  import servile_arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] gnt,
  output logic       valid
);

  always_comb begin
    gnt = 3'b000;
    case (ptr)
      M_IBUS: begin
        if      (req[0]) gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
      end
      M_DBUS: begin
        if      (req[1]) gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
      end
      default: begin
        if      (req[2]) gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
      end
    endcase
  end

  assign valid = |req;

endmodule

// File: rtl/servile_mem_arbiter.sv
// Three-master round-robin arbiter in front of the shared SRAM/RF Wishbone
// port, one transaction in flight, with ibus/dbus blocked from the RF region.
module servile_mem_arbiter
  import servile_arb_pkg::*;
#(
  parameter  int depth   = 256,
  parameter  int rf_regs = 32,
  localparam int aw      = $clog2(depth),
  localparam int rf_base = (depth - rf_regs*4)/4
) (
  input logic                  i_clk,
  input logic                  i_rst,
  servile_mem_arbiter_if.slave bus
);

  typedef logic [aw-3:0] word_adr_t;

  arb_state_t state_q;
  logic [1:0] ptr_q;
  logic [1:0] grant_q;

  logic [2:0] pick_gnt;
  logic       pick_valid;
  logic [1:0] pick_idx;
  logic       pick_guard;
  word_adr_t  mux_adr;
  logic       done;

  servile_rr_pick u_pick (
    .req   ({bus.i_ext_stb, bus.i_dbus_stb, bus.i_ibus_stb}),
    .ptr   (ptr_q),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  always_comb begin
    pick_idx = M_IBUS;
    if (pick_gnt[M_DBUS]) pick_idx = M_DBUS;
    if (pick_gnt[M_EXT])  pick_idx = M_EXT;
  end

  // ext is deliberately exempt so it can preload the register file.
  assign pick_guard =
    ((pick_idx == M_IBUS) && in_rf_region(32'(bus.i_ibus_adr), 32'(rf_base))) ||
    ((pick_idx == M_DBUS) && in_rf_region(32'(bus.i_dbus_adr), 32'(rf_base)));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= M_IBUS;
      grant_q <= M_IBUS;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            grant_q <= pick_idx;
            state_q <= pick_guard ? ST_GUARD : ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (bus.i_wb_ack) state_q <= ST_RECOVER;
        end
        ST_GUARD: state_q <= ST_RECOVER;
        ST_RECOVER: begin
          ptr_q   <= next_master(grant_q);
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // ibus is a read-only port, so its write controls are forced.
  always_comb begin
    mux_adr      = bus.i_ibus_adr;
    bus.o_wb_dat = 32'h0;
    bus.o_wb_sel = 4'hF;
    bus.o_wb_we  = 1'b0;
    case (grant_q)
      M_DBUS: begin
        mux_adr      = bus.i_dbus_adr;
        bus.o_wb_dat = bus.i_dbus_dat;
        bus.o_wb_sel = bus.i_dbus_sel;
        bus.o_wb_we  = bus.i_dbus_we;
      end
      M_EXT: begin
        mux_adr      = bus.i_ext_adr;
        bus.o_wb_dat = bus.i_ext_dat;
        bus.o_wb_sel = bus.i_ext_sel;
        bus.o_wb_we  = bus.i_ext_we;
      end
      default: ;
    endcase
  end

  assign bus.o_wb_adr    = mux_adr;
  assign bus.o_wb_stb    = (state_q == ST_GRANT);
  assign bus.o_guard_err = (state_q == ST_GUARD);

  // Slave acks outside GRANT never reach a master.
  assign done = ((state_q == ST_GRANT) && bus.i_wb_ack) || (state_q == ST_GUARD);

  assign bus.o_ibus_ack = done && (grant_q == M_IBUS);
  assign bus.o_dbus_ack = done && (grant_q == M_DBUS);
  assign bus.o_ext_ack  = done && (grant_q == M_EXT);

  assign bus.o_ibus_rdt = (bus.o_ibus_ack && state_q == ST_GRANT) ? bus.i_wb_rdt : 32'h0;
  assign bus.o_dbus_rdt = (bus.o_dbus_ack && state_q == ST_GRANT) ? bus.i_wb_rdt : 32'h0;
  assign bus.o_ext_rdt  = (bus.o_ext_ack  && state_q == ST_GRANT) ? bus.i_wb_rdt : 32'h0;

endmodule
